// File: rtl/decode_pipe.sv
// ID stage: decodes one RV32(F) instruction per cycle, resolves bypassing, registers into ID/EX.
// One-cycle latency; stalls on load-use hazards and while execute withholds out_ready.
module decode_pipe #(
    parameter int XLEN  = 32,
    parameter int RADDR = 6,
    parameter int NFWD  = 2,
    localparam int FW    = $clog2(NFWD + 1),
    localparam int CTRLW = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_instr,
    output logic [RADDR-1:0]     rs0,
    output logic [RADDR-1:0]     rs1,
    input  logic [XLEN-1:0]      rs0data,
    input  logic [XLEN-1:0]      rs1data,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [FW-1:0]        fwd_sel0,
    input  logic [FW-1:0]        fwd_sel1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_imm,
    output logic [RADDR-1:0]     out_rd,
    output logic [RADDR-1:0]     out_rs0,
    output logic [RADDR-1:0]     out_rs1,
    output logic [XLEN-1:0]      out_rdata0,
    output logic [XLEN-1:0]      out_rdata1,
    output logic [XLEN-1:0]      out_src0,
    output logic [XLEN-1:0]      out_src1,
    output logic [CTRLW-1:0]     out_ctrl
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_FP     = 7'b1010011;
    localparam logic [6:0] OP_IMEM   = 7'b0001011;

    localparam logic [1:0] S0_RDATA = 2'd0;
    localparam logic [1:0] S0_ZERO  = 2'd1;
    localparam logic [1:0] S0_PC    = 2'd2;
    localparam logic [1:0] S0_NONE  = 2'd3;
    localparam logic [1:0] S1_RDATA = 2'd0;
    localparam logic [1:0] S1_FOUR  = 2'd1;
    localparam logic [1:0] S1_IMM   = 2'd2;
    localparam logic [1:0] S1_NONE  = 2'd3;

    localparam int CB_MEMREAD = 20;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  funct5;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct5 = in_instr[31:27];
    assign i_imm  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign s_imm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign b_imm  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
    assign u_imm  = {in_instr[31:12], 12'b0};
    assign j_imm  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};

    logic        c_memtoreg, c_memwrite, c_memread, c_imemwrite, c_branchjump;
    logic [3:0]  c_aluop;
    logic [4:0]  c_fpuop;
    logic [2:0]  c_branchop;
    logic [1:0]  c_src0, c_src1;
    logic        c_regwrite, c_aluorfpu;
    logic        rd_fp, rs0_fp, rs1_fp;
    logic [31:0] imm32;

    // Control and immediate generation share one opcode decode.
    always_comb begin
        c_memtoreg   = 1'b0;
        c_memwrite   = 1'b0;
        c_memread    = 1'b0;
        c_imemwrite  = 1'b0;
        c_branchjump = 1'b0;
        c_aluop      = 4'd0;
        c_fpuop      = 5'd0;
        c_branchop   = 3'd0;
        c_src0       = S0_NONE;
        c_src1       = S1_NONE;
        c_regwrite   = 1'b0;
        c_aluorfpu   = 1'b0;
        rd_fp        = 1'b0;
        rs0_fp       = 1'b0;
        rs1_fp       = 1'b0;
        imm32        = 32'd0;
        case (opcode)
            OP_LUI: begin
                c_src0 = S0_ZERO; c_src1 = S1_IMM; c_regwrite = 1'b1; imm32 = u_imm;
            end
            OP_AUIPC: begin
                c_src0 = S0_PC; c_src1 = S1_IMM; c_regwrite = 1'b1; imm32 = u_imm;
            end
            OP_JAL: begin
                c_src0 = S0_PC; c_src1 = S1_FOUR; c_regwrite = 1'b1;
                c_branchjump = 1'b1; imm32 = j_imm;
            end
            OP_JALR: begin
                c_src0 = S0_PC; c_src1 = S1_FOUR; c_regwrite = 1'b1;
                c_branchjump = 1'b1; imm32 = i_imm;
            end
            OP_BRANCH: begin
                c_src0 = S0_RDATA; c_src1 = S1_RDATA; c_branchjump = 1'b1;
                c_branchop = funct3; imm32 = b_imm;
            end
            OP_LOAD, OP_FLW: begin
                c_src0 = S0_RDATA; c_src1 = S1_IMM; c_regwrite = 1'b1;
                c_memread = 1'b1; c_memtoreg = 1'b1; imm32 = i_imm;
                rd_fp = (opcode == OP_FLW);
            end
            OP_STORE, OP_FSW: begin
                c_src0 = S0_RDATA; c_src1 = S1_IMM; c_memwrite = 1'b1; imm32 = s_imm;
                rs1_fp = (opcode == OP_FSW);
            end
            OP_IMEM: begin
                c_src0 = S0_RDATA; c_src1 = S1_IMM; c_imemwrite = 1'b1; imm32 = s_imm;
            end
            OP_IMM: begin
                c_src0 = S0_RDATA; c_src1 = S1_IMM; c_regwrite = 1'b1; imm32 = i_imm;
                c_aluop = {(funct3 == 3'b101) & in_instr[30], funct3};
            end
            OP_REG: begin
                c_src0 = S0_RDATA; c_src1 = S1_RDATA; c_regwrite = 1'b1;
                c_aluop = {in_instr[30], funct3};
            end
            OP_FP: begin
                // compares, fcvt.w.s and fmv.x.w/fclass write the integer file;
                // fcvt.s.w and fmv.w.x read it.
                c_src0 = S0_RDATA; c_src1 = S1_RDATA; c_regwrite = 1'b1;
                c_aluorfpu = 1'b1; c_fpuop = funct5;
                rd_fp  = !(funct5 inside {5'b10100, 5'b11000, 5'b11100});
                rs0_fp = !(funct5 inside {5'b11010, 5'b11110});
                rs1_fp = 1'b1;
            end
            default: ;
        endcase
    end

    logic uses_rs0, uses_rs1, hazard;
    logic [RADDR-1:0] rd;

    assign uses_rs0 = (c_src0 == S0_RDATA) || (opcode == OP_JALR);
    assign uses_rs1 = (c_src1 == S1_RDATA) || c_memwrite || c_imemwrite;

    assign rs0 = {rs0_fp, (RADDR-1)'(in_instr[19:15])};
    assign rs1 = {rs1_fp, (RADDR-1)'(in_instr[24:20])};
    assign rd  = {rd_fp,  (RADDR-1)'(in_instr[11:7])};

    // Full-width index compare, so a float index never aliases its integer twin.
    assign hazard = out_valid && out_ctrl[CB_MEMREAD] && (out_rd != '0) &&
                    ((out_rd == rs0 && uses_rs0) || (out_rd == rs1 && uses_rs1));

    assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);

    function automatic logic [XLEN-1:0] fwd_pick(input logic [FW-1:0]        sel,
                                                 input logic [XLEN-1:0]      rf,
                                                 input logic [NFWD*XLEN-1:0] fd);
        logic [XLEN-1:0] v;
        v = '0;
        if (sel == '0) begin
            v = rf;
        end else begin
            for (int k = 1; k <= NFWD; k++) begin
                if (int'(sel) == k) v = fd[(k-1)*XLEN +: XLEN];
            end
        end
        return v;
    endfunction

    logic [XLEN-1:0]  rdata0, rdata1, src0_d, src1_d, imm;
    logic [CTRLW-1:0] ctrl_d;

    assign rdata0 = fwd_pick(fwd_sel0, rs0data, fwd_data);
    assign rdata1 = fwd_pick(fwd_sel1, rs1data, fwd_data);
    assign imm    = XLEN'($signed(imm32));
    assign ctrl_d = {c_memtoreg, c_memwrite, c_memread, c_imemwrite, c_branchjump,
                     c_aluop, c_fpuop, c_branchop, c_src0, c_src1, c_regwrite, c_aluorfpu};

    always_comb begin
        case (c_src0)
            S0_RDATA: src0_d = rdata0;
            S0_PC:    src0_d = in_pc;
            default:  src0_d = '0;
        endcase
        case (c_src1)
            S1_RDATA: src1_d = rdata1;
            S1_FOUR:  src1_d = XLEN'(4);
            S1_IMM:   src1_d = imm;
            default:  src1_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_imm    <= '0;
            out_rd     <= '0;
            out_rs0    <= '0;
            out_rs1    <= '0;
            out_rdata0 <= '0;
            out_rdata1 <= '0;
            out_src0   <= '0;
            out_src1   <= '0;
            out_ctrl   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid  <= 1'b1;
            out_pc     <= in_pc;
            out_imm    <= imm;
            out_rd     <= rd;
            out_rs0    <= rs0;
            out_rs1    <= rs1;
            out_rdata0 <= rdata0;
            out_rdata1 <= rdata1;
            out_src0   <= src0_d;
            out_src1   <= src1_d;
            out_ctrl   <= ctrl_d;
        end else if (out_valid && out_ready) begin
            // Also the bubble left behind when a load-use hazard blocks the next accept.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: fixed vectors, hand-written corner sequences, random stream vs model.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_instr, rs0data, rs1data;
    logic [5:0]  rs0, rs1, out_rd, out_rs0, out_rs1;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_sel0, fwd_sel1;
    logic [31:0] out_pc, out_imm, out_rdata0, out_rdata1, out_src0, out_src1;
    logic [22:0] out_ctrl;

    always #5 clk = ~clk;

    decode_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .rs0(rs0), .rs1(rs1),
        .rs0data(rs0data), .rs1data(rs1data), .fwd_data(fwd_data),
        .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm), .out_rd(out_rd), .out_rs0(out_rs0),
        .out_rs1(out_rs1), .out_rdata0(out_rdata0), .out_rdata1(out_rdata1),
        .out_src0(out_src0), .out_src1(out_src1), .out_ctrl(out_ctrl)
    );

    typedef enum int {K_ADDI, K_ADD, K_LW, K_SW, K_BEQ, K_LUI, K_AUIPC, K_JAL, K_JALR,
                      K_FLW, K_FADD} kind_e;

    typedef struct {
        kind_e       k;
        int          rd;
        logic [31:0] pc, imm, src0, src1, rdata0, rdata1;
        bit          wr, cimm;
    } exp_t;

    typedef struct {
        kind_e       k;
        int          rd, ra, rb, imm;
        logic [31:0] pc, r0, r1, f0, f1;
        logic [1:0]  s0, s1;
        logic [31:0] e_src0, e_src1, e_rdata0, e_imm;
        bit          c_imm;
    } vec_t;

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc(kind_e k, int rd, int ra, int rb, int imm);
        logic [31:0] im;
        logic [4:0]  d, a, b;
        im = imm; d = 5'(rd); a = 5'(ra); b = 5'(rb);
        case (k)
            K_ADDI:  return {im[11:0], a, 3'b000, d, 7'b0010011};
            K_ADD:   return {7'b0, b, a, 3'b000, d, 7'b0110011};
            K_LW:    return {im[11:0], a, 3'b010, d, 7'b0000011};
            K_SW:    return {im[11:5], b, a, 3'b010, im[4:0], 7'b0100011};
            K_BEQ:   return {im[12], im[10:5], b, a, 3'b000, im[4:1], im[11], 7'b1100011};
            K_LUI:   return {im[19:0], d, 7'b0110111};
            K_AUIPC: return {im[19:0], d, 7'b0010111};
            K_JAL:   return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
            K_JALR:  return {im[11:0], a, 3'b000, d, 7'b1100111};
            K_FLW:   return {im[11:0], a, 3'b010, d, 7'b0000111};
            default: return {7'b0, b, a, 3'b000, d, 7'b1010011};
        endcase
    endfunction

    function automatic bit uses0(kind_e k);
        return k inside {K_ADDI, K_ADD, K_LW, K_SW, K_BEQ, K_JALR};
    endfunction

    function automatic bit uses1(kind_e k);
        return k inside {K_ADD, K_SW, K_BEQ};
    endfunction

    function automatic logic [31:0] pick(logic [1:0] sel, logic [31:0] rf, logic [63:0] fd);
        case (sel)
            2'd0:    return rf;
            2'd1:    return fd[31:0];
            2'd2:    return fd[63:32];
            default: return 32'd0;
        endcase
    endfunction

    // Architectural meaning of each instruction kind, from the operand-select rules.
    function automatic exp_t model(kind_e k, int rd, int imm, logic [31:0] pc,
                                   logic [31:0] r0, logic [31:0] r1);
        exp_t e;
        e.k = k; e.rd = rd; e.pc = pc; e.rdata0 = r0; e.rdata1 = r1;
        e.imm  = (k == K_LUI || k == K_AUIPC) ? (32'(imm) << 12) : 32'(imm);
        e.wr   = !(k inside {K_SW, K_BEQ});
        e.cimm = (k != K_ADD);
        case (k)
            K_ADDI, K_LW, K_SW: begin e.src0 = r0;  e.src1 = e.imm; end
            K_LUI:              begin e.src0 = 0;   e.src1 = e.imm; end
            K_AUIPC:            begin e.src0 = pc;  e.src1 = e.imm; end
            K_JAL, K_JALR:      begin e.src0 = pc;  e.src1 = 32'd4; end
            default:            begin e.src0 = r0;  e.src1 = r1;    end
        endcase
        return e;
    endfunction

    function automatic vec_t mk(kind_e k, int rd, int ra, int rb, int imm, logic [31:0] pc,
                                logic [31:0] r0, logic [31:0] r1, logic [31:0] f0,
                                logic [31:0] f1, logic [1:0] s0, logic [1:0] s1,
                                logic [31:0] es0, logic [31:0] es1, logic [31:0] erd0,
                                logic [31:0] eimm, bit cimm);
        vec_t v;
        v.k = k; v.rd = rd; v.ra = ra; v.rb = rb; v.imm = imm; v.pc = pc;
        v.r0 = r0; v.r1 = r1; v.f0 = f0; v.f1 = f1; v.s0 = s0; v.s1 = s1;
        v.e_src0 = es0; v.e_src1 = es1; v.e_rdata0 = erd0; v.e_imm = eimm; v.c_imm = cimm;
        return v;
    endfunction

    task automatic offer(kind_e k, int rd, int ra, int rb, int imm, logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = enc(k, rd, ra, rb, imm);
        in_pc    = pc;
    endtask

    vec_t  tbl[10];
    exp_t  q[$];
    exp_t  e;
    kind_e kinds[9] = '{K_ADDI, K_ADD, K_LW, K_SW, K_BEQ, K_LUI, K_AUIPC, K_JAL, K_JALR};
    kind_e ck;
    int    crd, cra, crb, cimm;
    logic [31:0] cpc;
    bit    have_cur, haz, exp_rdy;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        rs0data = 0; rs1data = 0; fwd_data = 0; fwd_sel0 = 0; fwd_sel1 = 0;
        offer(K_ADDI, 1, 0, 0, 5, 32'h0);

        // Reset held three cycles with an instruction on offer.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_out_src0", out_src0, 0);
        end
        rst = 1'b0;
        #1 chk("rst_release_rdy", 32'(in_ready), 1);
        cyc();
        chk("rst_first_accept", 32'(out_valid), 1);
        in_valid = 1'b0;
        cyc();

        // Streaming four ADDIs back to back.
        for (int i = 0; i < 4; i++) begin
            offer(K_ADDI, i + 1, 0, 0, 5, 32'(4 * i));
            #1 chk("stream_in_ready", 32'(in_ready), 1);
            cyc();
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_pc", out_pc, 32'(4 * i));
            chk("stream_src1", out_src1, 5);
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_drain", 32'(out_valid), 0);

        // Load-use: one bubble then the dependent ADD issues.
        offer(K_LW, 5, 1, 0, 0, 32'h20);
        cyc();
        offer(K_ADD, 6, 5, 7, 0, 32'h24);
        #1 chk("lu_stall_rdy", 32'(in_ready), 0);
        cyc();
        chk("lu_bubble", 32'(out_valid), 0);
        chk("lu_retry_rdy", 32'(in_ready), 1);
        cyc();
        chk("lu_add_valid", 32'(out_valid), 1);
        chk("lu_add_rd", 32'(out_rd), 6);
        in_valid = 1'b0;
        cyc();

        // Load to x0 never hazards.
        offer(K_LW, 0, 1, 0, 0, 32'h28);
        cyc();
        offer(K_ADD, 6, 0, 7, 0, 32'h2c);
        #1 chk("lu_x0_rdy", 32'(in_ready), 1);
        cyc();
        chk("lu_x0_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        cyc();

        // Float loads hazard only against float readers of the same index.
        offer(K_FLW, 5, 1, 0, 0, 32'h30);
        cyc();
        chk("flw_rd_float", 32'(out_rd), 32'h25);
        offer(K_FADD, 6, 5, 7, 0, 32'h34);
        #1 chk("flw_fadd_rdy", 32'(in_ready), 0);
        in_valid = 1'b0;
        cyc();
        cyc();
        offer(K_FLW, 5, 1, 0, 0, 32'h38);
        cyc();
        offer(K_ADD, 6, 5, 7, 0, 32'h3c);
        #1 chk("flw_int_add_rdy", 32'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        cyc();

        // Backpressure: everything holds while out_ready is low.
        offer(K_ADDI, 3, 0, 0, 9, 32'h40);
        cyc();
        offer(K_ADDI, 4, 0, 0, 1, 32'h44);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_pc_hold", out_pc, 32'h40);
            chk("bp_src1_hold", out_src1, 9);
            chk("bp_valid_hold", 32'(out_valid), 1);
            cyc();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", 32'(in_ready), 1);
        cyc();
        chk("bp_next_pc", out_pc, 32'h44);
        in_valid = 1'b0;
        cyc();

        // Flush while stalled on a hazard drops the stalled ADD without a bubble.
        offer(K_LW, 5, 1, 0, 0, 32'h60);
        cyc();
        offer(K_ADD, 6, 5, 7, 0, 32'h64);
        flush = 1'b1;
        #1 chk("flush_rdy", 32'(in_ready), 0);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 0);
        cyc();
        chk("flush_clean", 32'(out_valid), 0);

        offer(K_JAL, 1, 0, 0, 32'h20, 32'h100);
        cyc();
        chk("jal_src0", out_src0, 32'h100);
        chk("jal_src1", out_src1, 4);
        chk("jal_ctrl_src", 32'(out_ctrl[5:2]), 32'h9);
        in_valid = 1'b0;
        cyc();

        // Fixed vectors.
        tbl[0] = mk(K_ADDI, 1, 0, 0, 5, 32'h0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 5, 1);
        tbl[1] = mk(K_ADDI, 2, 1, 0, -1, 32'h4, 32'h10, 0, 0, 0, 0, 0,
                    32'h10, 32'hFFFFFFFF, 32'h10, 32'hFFFFFFFF, 1);
        tbl[2] = mk(K_ADD, 3, 1, 2, 0, 32'h8, 1, 7, 0, 32'hDEADBEEF, 2, 0,
                    32'hDEADBEEF, 7, 32'hDEADBEEF, 0, 0);
        tbl[3] = mk(K_ADD, 3, 1, 2, 0, 32'hC, 1, 7, 32'h1234, 32'h5, 3, 1,
                    0, 32'h1234, 0, 0, 0);
        tbl[4] = mk(K_JAL, 1, 0, 0, 32'h20, 32'h100, 32'h55, 0, 0, 0, 0, 0,
                    32'h100, 4, 32'h55, 32'h20, 1);
        tbl[5] = mk(K_LUI, 4, 0, 0, 32'h12345, 32'h10, 0, 0, 0, 0, 0, 0,
                    0, 32'h12345000, 0, 32'h12345000, 1);
        tbl[6] = mk(K_AUIPC, 5, 0, 0, 1, 32'h200, 0, 0, 0, 0, 0, 0,
                    32'h200, 32'h1000, 0, 32'h1000, 1);
        tbl[7] = mk(K_SW, 0, 2, 3, -4, 32'h14, 32'h80, 0, 32'h99, 0, 1, 0,
                    32'h99, 32'hFFFFFFFC, 32'h99, 32'hFFFFFFFC, 1);
        tbl[8] = mk(K_BEQ, 0, 1, 2, -8, 32'h18, 3, 4, 0, 0, 0, 0,
                    3, 4, 3, 32'hFFFFFFF8, 1);
        tbl[9] = mk(K_JALR, 1, 6, 0, 16, 32'h40, 32'h1000, 0, 0, 0, 0, 0,
                    32'h40, 4, 32'h1000, 32'h10, 1);
        for (int i = 0; i < 10; i++) begin
            offer(tbl[i].k, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].imm, tbl[i].pc);
            rs0data = tbl[i].r0; rs1data = tbl[i].r1;
            fwd_data = {tbl[i].f1, tbl[i].f0};
            fwd_sel0 = tbl[i].s0; fwd_sel1 = tbl[i].s1;
            cyc();
            chk($sformatf("vec%0d_src0", i), out_src0, tbl[i].e_src0);
            chk($sformatf("vec%0d_src1", i), out_src1, tbl[i].e_src1);
            chk($sformatf("vec%0d_rdata0", i), out_rdata0, tbl[i].e_rdata0);
            if (tbl[i].c_imm) chk($sformatf("vec%0d_imm", i), out_imm, tbl[i].e_imm);
        end
        in_valid = 1'b0;
        fwd_sel0 = 0; fwd_sel1 = 0;
        cyc();

        // Random stream with backpressure, forwarding and occasional flushes.
        have_cur = 1'b0;
        cpc = 32'h1000;
        for (int n = 0; n < 3000; n++) begin
            if (!have_cur && $urandom_range(0, 3) != 0) begin
                ck  = kinds[$urandom_range(0, 8)];
                crd = int'($urandom_range(0, 7));
                cra = int'($urandom_range(0, 7));
                crb = int'($urandom_range(0, 7));
                case (ck)
                    K_BEQ:          cimm = (int'($urandom_range(0, 4095)) - 2048) * 2;
                    K_JAL:          cimm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                    K_LUI, K_AUIPC: cimm = int'($urandom_range(0, 1048575));
                    default:        cimm = int'($urandom_range(0, 4095)) - 2048;
                endcase
                cpc = cpc + 4;
                have_cur = 1'b1;
            end
            if (have_cur) offer(ck, crd, cra, crb, cimm, cpc);
            else begin
                in_valid = 1'b0; in_instr = 32'h00000013; in_pc = 0;
            end
            rs0data  = $urandom; rs1data = $urandom;
            fwd_data = {$urandom, $urandom};
            fwd_sel0 = 2'($urandom_range(0, 3));
            fwd_sel1 = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            #1;
            haz = have_cur && q.size() != 0 && q[0].k == K_LW && q[0].rd != 0 &&
                  ((uses0(ck) && cra == q[0].rd) || (uses1(ck) && crb == q[0].rd));
            exp_rdy = !flush && !haz && (q.size() == 0 || out_ready);
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (!flush && out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("rnd_pc", out_pc, e.pc);
                chk("rnd_src0", out_src0, e.src0);
                chk("rnd_src1", out_src1, e.src1);
                chk("rnd_rdata0", out_rdata0, e.rdata0);
                chk("rnd_rdata1", out_rdata1, e.rdata1);
                if (e.cimm) chk("rnd_imm", out_imm, e.imm);
                if (e.wr) chk("rnd_rd", 32'(out_rd), 32'(e.rd));
            end
            if (flush) begin
                q.delete();
                have_cur = 1'b0;
            end else if (have_cur && exp_rdy) begin
                q.push_back(model(ck, crd, cimm, cpc, pick(fwd_sel0, rs0data, fwd_data),
                                  pick(fwd_sel1, rs1data, fwd_data)));
                have_cur = 1'b0;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
